// File: rtl/hspi_link_ctrl.sv
// hspi_link_ctrl: half-duplex controller for the 16-bit HSPI pad bus.
// Owns pad direction (hspi_oen), RX/TX turnaround, and TX burst sequencing
// out of a small internal FIFO. Inbound words are captured only while idle
// in receive.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   tx_valid/tx_ready/tx_data   core-side TX push into the FIFO
//   rx_valid/rx_data      one-cycle pulse with the captured RX word
//   clear_err/collision   sticky collision flag and its clear
//   busy                  not in RX_IDLE, or FIFO holds words
//   hspi_oen              1 = pads are inputs, 0 = pads driven
//   hspi_tx_enable/hspi_tx_data  pad TX strobe and word
//   hspi_rx_enable/hspi_rx_data  pad RX strobe and word
//
// Optional: define HSPI_STATS_EN to add tx_word_cnt / rx_word_cnt outputs.
module hspi_link_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TURNAROUND = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] tx_data,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  input  logic        clear_err,
  output logic        collision,
  output logic        busy,
  output logic        hspi_oen,
  output logic        hspi_tx_enable,
  output logic [15:0] hspi_tx_data,
  input  logic        hspi_rx_enable,
  input  logic [15:0] hspi_rx_data
`ifdef HSPI_STATS_EN
  ,
  output logic [15:0] tx_word_cnt,
  output logic [15:0] rx_word_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURNAROUND - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    TURN_TX,
    TX,
    TURN_RX
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] turn_cnt, turn_cnt_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign tx_ready = (count != FIFO_FULL);
  assign push     = tx_valid && tx_ready;

  // Pad controls decode straight from the state register.
  assign hspi_oen       = (state == RX_IDLE) || (state == TURN_RX);
  assign hspi_tx_enable = (state == TX);
  assign busy           = (state != RX_IDLE) || (count != '0);

  // A pop is issued one cycle ahead of the TX cycle that shows the word:
  // the last TURN_TX cycle loads the first word, and each TX cycle that
  // continues the burst loads the next. burst_cnt is the index of the word
  // currently on the pads.
  always_comb begin
    state_nxt     = state;
    turn_cnt_nxt  = turn_cnt;
    burst_cnt_nxt = burst_cnt;
    pop           = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!hspi_rx_enable && (count != '0)) begin
          state_nxt    = TURN_TX;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      TURN_TX: begin
        if (turn_cnt != '0) begin
          turn_cnt_nxt = turn_cnt - 1'b1;
        end else begin
          state_nxt     = TX;
          burst_cnt_nxt = '0;
          pop           = 1'b1;
        end
      end
      TX: begin
        if ((count == '0) || (burst_cnt == BURST_LAST)) begin
          state_nxt    = TURN_RX;
          turn_cnt_nxt = TURN_LOAD;
        end else begin
          pop           = 1'b1;
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end
      TURN_RX: begin
        if (turn_cnt != '0) begin
          turn_cnt_nxt = turn_cnt - 1'b1;
        end else begin
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RX_IDLE;
      turn_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      turn_cnt  <= turn_cnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // FIFO storage needs no reset; pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hspi_tx_data <= '0;
    end else if (pop) begin
      hspi_tx_data <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= (state == RX_IDLE) && hspi_rx_enable;
      if ((state == RX_IDLE) && hspi_rx_enable) begin
        rx_data <= hspi_rx_data;
      end
    end
  end

  // Peer strobing while we own the bus; set wins over clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      collision <= 1'b0;
    end else if (hspi_rx_enable && ((state == TURN_TX) || (state == TX))) begin
      collision <= 1'b1;
    end else if (clear_err) begin
      collision <= 1'b0;
    end
  end

`ifdef HSPI_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_word_cnt <= '0;
      rx_word_cnt <= '0;
    end else begin
      if (hspi_tx_enable) tx_word_cnt <= tx_word_cnt + 1'b1;
      if (rx_valid)       rx_word_cnt <= rx_word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hspi_link_ctrl.sv
// tb_hspi_link_ctrl: directed self-checking bench for hspi_link_ctrl
// (FIFO_DEPTH=8, TURNAROUND=2, MAX_BURST=16). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_hspi_link_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        clear_err;
  logic        collision;
  logic        busy;
  logic        hspi_oen;
  logic        hspi_tx_enable;
  logic [15:0] hspi_tx_data;
  logic        hspi_rx_enable;
  logic [15:0] hspi_rx_data;

  int checks = 0;
  int errors = 0;

  hspi_link_ctrl #(
    .FIFO_DEPTH(8),
    .TURNAROUND(2),
    .MAX_BURST (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .clear_err     (clear_err),
    .collision     (collision),
    .busy          (busy),
    .hspi_oen      (hspi_oen),
    .hspi_tx_enable(hspi_tx_enable),
    .hspi_tx_data  (hspi_tx_data),
    .hspi_rx_enable(hspi_rx_enable),
    .hspi_rx_data  (hspi_rx_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 (tag, hspi_oen, 1'b1);
    chk1 (tag, hspi_tx_enable, 1'b0);
    chk16(tag, hspi_tx_data, 16'h0000);
    chk1 (tag, rx_valid, 1'b0);
    chk16(tag, rx_data, 16'h0000);
    chk1 (tag, collision, 1'b0);
    chk1 (tag, tx_ready, 1'b1);
    chk1 (tag, busy, 1'b0);
  endtask

  initial begin
    logic en_exp;
    logic oen_exp;
    int   widx;

    reset          = 1'b1;
    tx_valid       = 1'b0;
    tx_data        = '0;
    clear_err      = 1'b0;
    hspi_rx_enable = 1'b0;
    hspi_rx_data   = '0;
    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Idle: nothing should move.
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("idle_oen", hspi_oen, 1'b1);
      chk1("idle_txen", hspi_tx_enable, 1'b0);
      chk1("idle_ready", tx_ready, 1'b1);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_rxv", rx_valid, 1'b0);
    end

    // Three-word burst: pushes in cycles T..T+2.
    tx_valid = 1'b1; tx_data = 16'h1111;               // T
    chk1("b3_oen_T", hspi_oen, 1'b1);
    step();                                            // T+1
    chk1("b3_busy_T1", busy, 1'b1);
    chk1("b3_oen_T1", hspi_oen, 1'b1);
    tx_data = 16'h2222;
    step();                                            // T+2
    chk1("b3_oen_T2", hspi_oen, 1'b0);
    chk1("b3_txen_T2", hspi_tx_enable, 1'b0);
    tx_data = 16'h3333;
    step();                                            // T+3
    tx_valid = 1'b0;
    chk1("b3_oen_T3", hspi_oen, 1'b0);
    chk1("b3_txen_T3", hspi_tx_enable, 1'b0);
    step();                                            // T+4
    chk1 ("b3_txen_T4", hspi_tx_enable, 1'b1);
    chk16("b3_data_T4", hspi_tx_data, 16'h1111);
    step();                                            // T+5
    chk1 ("b3_txen_T5", hspi_tx_enable, 1'b1);
    chk16("b3_data_T5", hspi_tx_data, 16'h2222);
    step();                                            // T+6
    chk1 ("b3_txen_T6", hspi_tx_enable, 1'b1);
    chk16("b3_data_T6", hspi_tx_data, 16'h3333);
    step();                                            // T+7
    chk1 ("b3_txen_T7", hspi_tx_enable, 1'b0);
    chk1 ("b3_oen_T7", hspi_oen, 1'b1);
    chk16("b3_hold_T7", hspi_tx_data, 16'h3333);
    step();                                            // T+8
    chk1("b3_oen_T8", hspi_oen, 1'b1);
    chk1("b3_busy_T8", busy, 1'b1);
    step();                                            // T+9
    chk1("b3_busy_T9", busy, 1'b0);

    // Twenty words, one push per cycle: bursts of 16 then 4.
    // TX cycles k=4..19 and k=25..28; pads driven k=2..19 and k=23..28.
    widx = 0;
    for (int k = 0; k < 34; k++) begin
      if (k < 20) begin
        tx_valid = 1'b1;
        tx_data  = 16'h0100 + 16'(k);
        chk1("b20_ready", tx_ready, 1'b1);
      end else begin
        tx_valid = 1'b0;
      end
      en_exp  = ((k >= 4) && (k <= 19)) || ((k >= 25) && (k <= 28));
      oen_exp = !(((k >= 2) && (k <= 19)) || ((k >= 23) && (k <= 28)));
      chk1("b20_txen", hspi_tx_enable, en_exp);
      chk1("b20_oen", hspi_oen, oen_exp);
      if (en_exp) begin
        chk16("b20_data", hspi_tx_data, 16'h0100 + 16'(widx));
        widx++;
      end
      step();
    end
    chk1("b20_busy_end", busy, 1'b0);

    // RX wins over pending TX.
    hspi_rx_enable = 1'b1; hspi_rx_data = 16'h0F0F;    // c0
    tx_valid = 1'b1; tx_data = 16'hB001;
    step();                                            // c1
    chk1 ("rx_valid_c1", rx_valid, 1'b1);
    chk16("rx_data_c1", rx_data, 16'h0F0F);
    chk1 ("rx_oen_c1", hspi_oen, 1'b1);
    tx_data = 16'hB002;
    step();                                            // c2
    tx_valid = 1'b0;
    hspi_rx_data = 16'hA5A5;
    chk1("rx_oen_c2", hspi_oen, 1'b1);
    step();                                            // c3
    hspi_rx_enable = 1'b0;
    chk1 ("rx_valid_c3", rx_valid, 1'b1);
    chk16("rx_data_c3", rx_data, 16'hA5A5);
    chk1 ("rx_oen_c3", hspi_oen, 1'b1);
    step();                                            // c4
    chk1("rx_valid_c4", rx_valid, 1'b0);
    chk1("rx_oen_c4", hspi_oen, 1'b0);
    chk1("rx_coll_c4", collision, 1'b0);
    step();                                            // c5
    chk1("rx_txen_c5", hspi_tx_enable, 1'b0);
    step();                                            // c6
    chk1 ("rx_txen_c6", hspi_tx_enable, 1'b1);
    chk16("rx_txd_c6", hspi_tx_data, 16'hB001);
    step();                                            // c7
    chk1 ("rx_txen_c7", hspi_tx_enable, 1'b1);
    chk16("rx_txd_c7", hspi_tx_data, 16'hB002);
    step();                                            // c8
    chk1("rx_txen_c8", hspi_tx_enable, 1'b0);
    chk1("rx_oen_c8", hspi_oen, 1'b1);
    step();                                            // c9
    step();                                            // c10
    chk1("rx_busy_c10", busy, 1'b0);

    // Collision during TX.
    tx_valid = 1'b1; tx_data = 16'hC001;               // c0
    step();
    tx_data = 16'hC002;                                // c1
    step();
    tx_data = 16'hC003;                                // c2
    step();
    tx_valid = 1'b0;                                   // c3
    step();                                            // c4
    chk16("col_txd_c4", hspi_tx_data, 16'hC001);
    step();                                            // c5
    chk16("col_txd_c5", hspi_tx_data, 16'hC002);
    chk1 ("col_c5", collision, 1'b0);
    hspi_rx_enable = 1'b1; hspi_rx_data = 16'hDEAD;
    step();                                            // c6
    chk1 ("col_c6", collision, 1'b1);
    chk1 ("col_txen_c6", hspi_tx_enable, 1'b1);
    chk16("col_txd_c6", hspi_tx_data, 16'hC003);
    chk1 ("col_rxv_c6", rx_valid, 1'b0);
    clear_err = 1'b1;
    step();                                            // c7
    chk1("col_setwins_c7", collision, 1'b1);
    chk1("col_oen_c7", hspi_oen, 1'b1);
    chk1("col_txen_c7", hspi_tx_enable, 1'b0);
    hspi_rx_enable = 1'b0;
    step();                                            // c8
    chk1("col_clear_c8", collision, 1'b0);
    clear_err = 1'b0;
    hspi_rx_enable = 1'b1;
    step();                                            // c9
    hspi_rx_enable = 1'b0;
    chk1 ("col_turnrx_c9", collision, 1'b0);
    chk1 ("col_rxv_c9", rx_valid, 1'b0);
    chk16("col_rxd_c9", rx_data, 16'hA5A5);
    chk1 ("col_busy_c9", busy, 1'b0);

    // Fill FIFO while RX holds the bus, then reset mid-burst.
    hspi_rx_enable = 1'b1; hspi_rx_data = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1;
      tx_data  = 16'hD000 + 16'(i);
      chk1("fill_ready", tx_ready, 1'b1);
      step();
    end
    chk1("full_ready_c8", tx_ready, 1'b0);
    chk1("full_busy_c8", busy, 1'b1);
    chk1("full_oen_c8", hspi_oen, 1'b1);
    tx_data = 16'hD008;
    step();                                            // c9
    chk1 ("full_ready_c9", tx_ready, 1'b0);
    chk1 ("full_rxv_c9", rx_valid, 1'b1);
    chk16("full_rxd_c9", rx_data, 16'h7777);
    tx_valid = 1'b0;
    hspi_rx_enable = 1'b0;
    step();                                            // c10
    chk1("full_oen_c10", hspi_oen, 1'b0);
    step();                                            // c11
    step();                                            // c12
    chk1 ("full_txen_c12", hspi_tx_enable, 1'b1);
    chk16("full_txd_c12", hspi_tx_data, 16'hD000);
    chk1 ("full_ready_c12", tx_ready, 1'b1);
    step();                                            // c13
    chk16("full_txd_c13", hspi_tx_data, 16'hD001);
    reset = 1'b1;
    step();                                            // c14
    chk_reset_vals("midreset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("post_busy", busy, 1'b0);
      chk1("post_oen", hspi_oen, 1'b1);
      chk1("post_txen", hspi_tx_enable, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
